// File: rtl/ls_pkg.sv
// Shared types and constants for the load/store sequencer.
package ls_pkg;
    localparam int MEM_AW = 5;
    localparam int DW     = 32;

    localparam logic [5:0] LW_OPCODE = 6'b100011;
    localparam logic [5:0] SW_OPCODE = 6'b101011;

    typedef enum logic [2:0] {
        IDLE,
        RDREG,
        AGEN,
        MEM,
        FIN
    } state_t;
endpackage

// File: rtl/ls_agen.sv
// Effective-address unit: sign-extends imm, adds it to the base register (mod 2^32)
// and flags addresses outside the memory window when LS_RANGE_CHECK_EN is defined.
module ls_agen
    import ls_pkg::*;
(
    input  logic [DW-1:0]     base,
    input  logic [15:0]       imm,
    output logic [MEM_AW-1:0] ea_lo,
    output logic              out_of_range
);
    logic [DW-1:0] ea;

    assign ea    = base + {{(DW-16){imm[15]}}, imm};
    assign ea_lo = ea[MEM_AW-1:0];

`ifdef LS_RANGE_CHECK_EN
    assign out_of_range = |ea[DW-1:MEM_AW];
`else
    // Upper address bits are deliberately discarded when the window is not checked.
    logic unused_ea_hi;
    assign unused_ea_hi = ^ea[DW-1:MEM_AW];
    assign out_of_range = 1'b0;
`endif
endmodule

// File: rtl/ls_sequencer.sv
// Multi-cycle LW/SW sequencer: IDLE -> RDREG -> AGEN -> MEM -> FIN, all outputs registered.
// Optional LS_RANGE_CHECK_EN rejects effective addresses beyond the 5-bit memory window.
module ls_sequencer
    import ls_pkg::*;
#(
    parameter logic [5:0] LW_OP = LW_OPCODE,
    parameter logic [5:0] SW_OP = SW_OPCODE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [5:0]        opcode,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [15:0]       imm,
    output logic [4:0]        rf_raddr_a,
    output logic [4:0]        rf_raddr_b,
    input  logic [DW-1:0]     rf_rdata_a,
    input  logic [DW-1:0]     rf_rdata_b,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DW-1:0]     rf_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic              mem_ack,
    input  logic [DW-1:0]     mem_rdata,
    output logic              done,
    output logic              err
);
    state_t              state_q, state_d;
    logic                is_lw_q, is_lw_d;
    logic [4:0]          rt_q, rt_d;
    logic [15:0]         imm_q, imm_d;
    logic [DW-1:0]       a_q, a_d, b_q, b_d;
    logic                instr_ready_q, instr_ready_d;
    logic [4:0]          rf_raddr_a_q, rf_raddr_a_d, rf_raddr_b_q, rf_raddr_b_d;
    logic                rf_we_q, rf_we_d;
    logic [4:0]          rf_waddr_q, rf_waddr_d;
    logic [DW-1:0]       rf_wdata_q, rf_wdata_d;
    logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]       mem_wdata_q, mem_wdata_d;
    logic                done_q, done_d, err_q, err_d;
    logic [MEM_AW-1:0]   agen_addr;
    logic                agen_oor;

    ls_agen u_agen (
        .base         (a_q),
        .imm          (imm_q),
        .ea_lo        (agen_addr),
        .out_of_range (agen_oor)
    );

    always_comb begin
        state_d       = state_q;
        is_lw_d       = is_lw_q;
        rt_d          = rt_q;
        imm_d         = imm_q;
        a_d           = a_q;
        b_d           = b_q;
        instr_ready_d = instr_ready_q;
        rf_raddr_a_d  = rf_raddr_a_q;
        rf_raddr_b_d  = rf_raddr_b_q;
        rf_we_d       = 1'b0;
        rf_waddr_d    = rf_waddr_q;
        rf_wdata_d    = rf_wdata_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        done_d        = 1'b0;
        err_d         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (instr_valid && instr_ready_q) begin
                    is_lw_d       = (opcode == LW_OP);
                    rt_d          = rt;
                    imm_d         = imm;
                    instr_ready_d = 1'b0;
                    if (opcode == LW_OP || opcode == SW_OP) begin
                        state_d      = RDREG;
                        rf_raddr_a_d = rs;
                        rf_raddr_b_d = rt;
                    end else begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            RDREG: begin
                a_d          = rf_rdata_a;
                b_d          = rf_rdata_b;
                rf_raddr_a_d = '0;
                rf_raddr_b_d = '0;
                state_d      = AGEN;
            end
            AGEN: begin
                if (agen_oor) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    state_d     = MEM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = !is_lw_q;
                    mem_addr_d  = agen_addr;
                    mem_wdata_d = b_q;
                end
            end
            MEM: begin
                // Request fields stay frozen until the acknowledge arrives.
                if (mem_ack) begin
                    state_d     = FIN;
                    done_d      = 1'b1;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    if (is_lw_q) begin
                        rf_we_d    = (rt_q != 5'd0);
                        rf_waddr_d = rt_q;
                        rf_wdata_d = mem_rdata;
                    end
                end
            end
            FIN: begin
                state_d       = IDLE;
                instr_ready_d = 1'b1;
                rf_waddr_d    = '0;
                rf_wdata_d    = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            is_lw_q       <= 1'b0;
            rt_q          <= '0;
            imm_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            instr_ready_q <= 1'b1;
            rf_raddr_a_q  <= '0;
            rf_raddr_b_q  <= '0;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            is_lw_q       <= is_lw_d;
            rt_q          <= rt_d;
            imm_q         <= imm_d;
            a_q           <= a_d;
            b_q           <= b_d;
            instr_ready_q <= instr_ready_d;
            rf_raddr_a_q  <= rf_raddr_a_d;
            rf_raddr_b_q  <= rf_raddr_b_d;
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign instr_ready = instr_ready_q;
    assign rf_raddr_a  = rf_raddr_a_q;
    assign rf_raddr_b  = rf_raddr_b_q;
    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign done        = done_q;
    assign err         = err_q;
endmodule

// File: doc/ls_sequencer.md
LS_SEQUENCER -- requirements
Module: ls_sequencer

Interface
REQ-001 SHALL have parameter LW_OP, default 6'b100011, the load-word opcode.
REQ-002 SHALL have parameter SW_OP, default 6'b101011, the store-word opcode.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 instr_valid  in  1  instruction offered.
REQ-006 instr_ready  out  1  sequencer can accept an instruction.
REQ-007 opcode  in  6; rs  in  5; rt  in  5; imm  in  16  instruction fields, sampled on accept.
REQ-008 rf_raddr_a, rf_raddr_b  out  5 each  register-file read addresses (rs, rt).
REQ-009 rf_rdata_a, rf_rdata_b  in  32 each  combinational register-file read data.
REQ-010 rf_we  out  1; rf_waddr  out  5; rf_wdata  out  32  register write-back port.
REQ-011 mem_req  out  1; mem_we  out  1; mem_addr  out  5; mem_wdata  out  32  memory request.
REQ-012 mem_ack  in  1; mem_rdata  in  32  memory completion, rdata valid with ack.
REQ-013 done  out  1  one-cycle completion pulse; err  out  1  error flag, valid with done.

Function
REQ-014 SHALL implement states IDLE, RDREG, AGEN, MEM, FIN.
REQ-015 instr_ready SHALL be 1 only in IDLE; accept = instr_valid & instr_ready.
REQ-016 On accept, SHALL latch opcode/rs/rt/imm and go to RDREG; opcode not LW_OP/SW_OP goes to FIN with err=1, no side effects.
REQ-017 RDREG: SHALL drive rf_raddr_a=rs, rf_raddr_b=rt, capture both rdata; go to AGEN.
REQ-018 AGEN: SHALL register ea = rdata_a + sign-extended imm, 32-bit, wrap-around modulo 2^32; go to MEM.
REQ-019 MEM: SHALL hold mem_req=1, mem_addr=ea[4:0], mem_we=1 for SW, mem_wdata=captured rt data, all stable until mem_ack; ack in same cycle as req is legal.
REQ-020 On mem_ack, LW SHALL capture mem_rdata; both go to FIN.
REQ-021 FIN: SHALL pulse done for one cycle; for LW without error, SHALL pulse rf_we with rf_waddr=rt, rf_wdata=loaded data; go to IDLE.
REQ-022 LW with rt=0 SHALL suppress rf_we; done still pulses.
REQ-023 Minimum latency accept-to-done: 4 cycles with zero-wait ack; each wait cycle adds one.
REQ-024 mem_ack outside MEM SHALL be ignored.
REQ-025 No new instruction SHALL be accepted in FIN; back-to-back throughput one per 5 cycles minimum.

Reset
REQ-026 rst_n low SHALL immediately force IDLE; instr_ready=1 after reset; mem_req, mem_we, rf_we, done, err=0; all address/data outputs 0.
REQ-027 Reset mid-MEM SHALL drop mem_req asynchronously; no write-back or done for the aborted instruction.

Configuration
REQ-028 Macro LS_RANGE_CHECK_EN: when defined, ea[31:5]!=0 SHALL skip MEM, go to FIN with err=1, no memory access, no rf write.
REQ-029 Without LS_RANGE_CHECK_EN, SHALL use ea[4:0] unconditionally and err SHALL be 1 only for illegal opcode.

Structure
REQ-030 Package ls_pkg SHALL hold state enumeration, LW/SW opcode constants, MEM_AW=5, DW=32.
REQ-031 Sub-module ls_agen SHALL contain sign-extension, adder and range check; FSM stays in ls_sequencer.

Verification
REQ-032 Reset, rf[2]=8, imm=4, LW rt=3, ack zero-wait, mem[12]=0xDEAD -> done 4 cycles after accept, rf_we, rf_waddr=3, rf_wdata=0xDEAD.
REQ-033 SW rs=1 (rf=1), imm=16'hFFFF, rt=5 (rf=0x55), ack delayed 3 cycles -> mem_addr=0, mem_we=1, wdata=0x55 held 4 cycles, done at latency 7, no rf_we.
REQ-034 opcode 6'b000000 -> done 1 cycle after accept, err=1, no mem_req, no rf_we.
REQ-035 With LS_RANGE_CHECK_EN, rs data=32, imm=0, LW -> err=1, no mem_req; without macro -> mem_addr=0, err=0.
REQ-036 rst_n low during MEM wait -> mem_req drops immediately, no done; next LW completes normally.
REQ-037 LW rt=0 -> done=1, rf_we stays 0; spurious mem_ack in IDLE -> no state change.
